conversion_arbiter: RTL and testbench
=====================================

// Module: conversion_arbiter
// PURPOSE
//  - Shares one converter (soc/eoc handshake, result on numero) among N_REQ requesters.
//  - Round-robin grant; one conversion per grant.
//  - Returns the result to the granted requester over a 4-phase req/ack handshake.
//  - Sits between the converter and consumers such as the square-wave generator, which
//    then talk to the arbiter instead of owning the converter.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  W      8  width of converter result / returned data
// PORTS
//  clock   in   1      single system clock, all state updates on posedge
//  reset   in   1      asynchronous, active-high
//  req     in   N_REQ  req[i]=1: requester i asks for one conversion (4-phase)
//  ack     out  N_REQ  one-hot or zero; ack[i]=1: dato valid for requester i
//  dato    out  W      last conversion result, stable while any ack bit is 1
//  soc     out  1      start of conversion to converter
//  eoc     in   1      end of conversion from converter (1 = idle / result valid)
//  numero  in   W      converter result, valid when eoc=1 after the soc falling edge
// BEHAVIOUR
//  - Reset (async, immediate): soc=0, ack=0, dato=0, state=IDLE, last=N_REQ-1 (req[0] first).
//  - IDLE, on edge with (req!=0 && eoc==1):
//      g = first i with req[i]=1, scanning last+1, last+2, ... mod N_REQ;
//      grant<=g; soc<=1; -> WAIT_EOC_LO.
//  - IDLE with req!=0 but eoc==0: wait; soc stays 0 (converter busy).
//  - WAIT_EOC_LO, eoc==0: soc<=0; -> WAIT_EOC_HI.
//  - WAIT_EOC_HI, eoc==1: dato<=numero; ack[grant]<=1; -> ACK.
//  - ACK, req[grant]==0: ack<=0; last<=grant; -> IDLE.
//  - Minimum latency, req rise to ack: 4 clocks with a 0-cycle converter.
//  - ack falls 1 clock after req[grant] falls.
//  - New grant at the earliest on the edge after ack falls.
//  - req is sampled only in IDLE.
//    A pulse that rises and falls while another requester is served is lost (legal).
//  - req[grant] dropped before ack (protocol violation):
//      conversion still completes and ack[grant] pulses for exactly 1 clock;
//      last updates normally. No hang.
//  - Non-granted req changes never affect the current transaction.
//  - Simultaneous requests: resolved only by the rotating pointer, never by index alone.
//  - A requester holding req continuously cannot starve others:
//    max wait = N_REQ-1 transactions.
//  - dato holds its value outside ACK (not cleared).
//  - numero is ignored except on the capture edge.
//  - Reset mid-transaction:
//      soc/ack drop immediately; the converter finishes on its own;
//      IDLE re-arms only when eoc==1.
//  - soc is a registered output; no combinational path from any input to any output.
// STRUCTURE
//  - Package conversion_arbiter_pkg:
//      state encoding (IDLE, WAIT_EOC_LO, WAIT_EOC_HI, ACK; 2 bits);
//      default N_REQ and W; grant index width = $clog2(N_REQ).
//  - Sub-module rr_picker:
//      combinational rotating-priority encoder (req, last -> g, any);
//      reusable by other shared-resource arbiters.
//  - Top: FSM, grant/last/dato registers, ack decode from grant.
// TESTING (behavioural converter model: on soc rise eoc<=0; on soc fall, after D clocks,
// present value and set eoc<=1)
//  1. reset=1 for 2 clocks, req=4'b1111
//     -> soc=0, ack=0, dato=0 throughout; no soc pulse until reset=0.
//  2. req=4'b0100 only, model returns 8'd42, D=3
//     -> exactly one soc pulse; ack=4'b0100 with dato=42;
//        req[2] low -> ack=0 next clock.
//  3. req=4'b1111 held (requesters re-raise after each ack), model returns 10,20,30,40
//     -> grant order 0,1,2,3,0; dato seen by each matches sequence.
//  4. after serving 1, req=4'b1001 held
//     -> order 3,0,3,0 (fairness, pointer starts at 2).
//  5. eoc forced 0 in IDLE with req=4'b0001 for 5 clocks
//     -> soc stays 0; soc rises 1 clock after eoc returns to 1.
//  6. reset asserted in WAIT_EOC_HI
//     -> soc=0, ack=0 within same timestep; after release, first grant goes to req[0].
//  - Every scenario: assert ack is one-hot-or-zero; soc never 1 in ACK state.
//  - Timeout 100000 time units fails the bench.

Source files
------------

// File: rtl/conversion_arbiter_pkg.sv
// Shared definitions for the converter arbiter: FSM state encoding, default
// sizes and the grant-index width helper.
package conversion_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_EOC_LO = 2'd1,
        ST_WAIT_EOC_HI = 2'd2,
        ST_ACK         = 2'd3
    } arb_state_e;

    localparam int N_REQ_DEFAULT = 4;
    localparam int W_DEFAULT     = 8;

    function automatic int grant_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conversion_arbiter_rr_picker.sv
// Combinational rotating-priority encoder: picks the first requester after
// 'last' (wrapping), so the most recently served requester has lowest priority.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int GW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    g,
    output logic             any
);

    logic [GW-1:0] idx_s;

    // Scan from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        g     = last;
        any   = 1'b0;
        idx_s = last;
        for (int k = N_REQ; k >= 1; k--) begin
            idx_s = GW'((int'(last) + k) % N_REQ);
            if (req[idx_s]) begin
                g   = idx_s;
                any = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/conversion_arbiter.sv
// Shares one soc/eoc converter among N_REQ requesters with round-robin grants
// and returns each result over a 4-phase req/ack handshake.
module conversion_arbiter
    import conversion_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int W     = W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [W-1:0]     dato,
    output logic             soc,
    input  logic             eoc,
    input  logic [W-1:0]     numero
);

    localparam int            GW       = grant_idx_width(N_REQ);
    localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q,  last_d;
    logic [W-1:0]     dato_q,  dato_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic             soc_q,   soc_d;

    logic [GW-1:0]    pick_g_s;
    logic             pick_any_s;
    logic [N_REQ-1:0] grant_oh_s;

    rr_picker #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .g     (pick_g_s),
        .any   (pick_any_s)
    );

    // One-hot decode of the current grant, used to raise ack.
    always_comb begin
        grant_oh_s          = {N_REQ{1'b0}};
        grant_oh_s[grant_q] = 1'b1;
    end

    // Next-state logic: one conversion per grant, then hold ack until req drops.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        dato_d  = dato_q;
        ack_d   = ack_q;
        soc_d   = soc_q;
        case (state_q)
            ST_IDLE: begin
                // A busy converter (eoc low) blocks new grants.
                if (pick_any_s && eoc) begin
                    grant_d = pick_g_s;
                    soc_d   = 1'b1;
                    state_d = ST_WAIT_EOC_LO;
                end else begin
                    soc_d   = 1'b0;
                end
            end
            ST_WAIT_EOC_LO: begin
                if (!eoc) begin
                    soc_d   = 1'b0;
                    state_d = ST_WAIT_EOC_HI;
                end else begin
                    soc_d   = 1'b1;
                end
            end
            ST_WAIT_EOC_HI: begin
                if (eoc) begin
                    dato_d  = numero;
                    ack_d   = grant_oh_s;
                    state_d = ST_ACK;
                end else begin
                    ack_d   = {N_REQ{1'b0}};
                end
            end
            ST_ACK: begin
                if (!req[grant_q]) begin
                    ack_d   = {N_REQ{1'b0}};
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else begin
                    ack_d   = grant_oh_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                soc_d   = 1'b0;
                ack_d   = {N_REQ{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= {GW{1'b0}};
            last_q  <= LAST_RST;
            dato_q  <= {W{1'b0}};
            ack_q   <= {N_REQ{1'b0}};
            soc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            dato_q  <= dato_d;
            ack_q   <= ack_d;
            soc_q   <= soc_d;
        end
    end

    assign ack  = ack_q;
    assign dato = dato_q;
    assign soc  = soc_q;

endmodule

// File: tb/tb_conversion_arbiter.sv
// Directed bench for conversion_arbiter: behavioural converter, handshaking
// requesters and a transaction-level round-robin model checked every cycle.
module tb_conversion_arbiter;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'd0;
    logic [3:0] ack;
    logic [7:0] dato;
    logic       soc;
    logic       eoc;
    logic [7:0] numero = 8'd0;

    logic eoc_c     = 1'b1;
    logic eoc_force = 1'b0;
    assign eoc = eoc_c & ~eoc_force;

    int errors = 0;
    int checks = 0;

    // converter model state
    logic       soc_prev = 1'b0;
    logic       pend     = 1'b0;
    int         cnt      = 0;
    int         conv_delay = 0;
    logic [7:0] vals [16];
    int         conv_idx = 0;
    logic [7:0] conv_last_val = 8'd0;

    // requester state
    int   budget [4] = '{default: 0};
    int   served [4] = '{default: 0};
    logic [3:0] acked = 4'd0;

    // reference model / monitor state
    logic [3:0] p_req  = 4'd0;
    logic [3:0] p_ack  = 4'd0;
    logic       p_soc  = 1'b0;
    logic       p_eoc  = 1'b1;
    logic [7:0] p_dato = 8'd0;
    int   mlast    = N - 1;
    logic exp_pend = 1'b0;
    logic in_ack   = 1'b0;
    int   exp_g    = 0;
    int   cur_g    = 0;
    int   n_done   = 0;
    int   n_soc    = 0;
    int   cur_len  = 0;
    int   ack_len  = 0;
    int   g_log [$];
    int   d_log [$];

    conversion_arbiter #(
        .N_REQ (N),
        .W     (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .ack    (ack),
        .dato   (dato),
        .soc    (soc),
        .eoc    (eoc),
        .numero (numero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Round-robin rule: first requester after the last served one, wrapping.
    function automatic int rr_expect(input logic [3:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Converter: eoc falls on soc rise; D clocks after soc falls the result
    // appears for one cycle, otherwise numero carries noise.
    always @(posedge clock) begin
        soc_prev <= soc;
        numero   <= 8'($urandom);
        if (soc && !soc_prev) eoc_c <= 1'b0;
        if (!soc && soc_prev) begin
            pend <= 1'b1;
            cnt  <= conv_delay;
        end else if (pend) begin
            if (cnt == 0) begin
                numero        <= vals[conv_idx];
                conv_last_val <= vals[conv_idx];
                conv_idx      <= (conv_idx + 1) % 16;
                eoc_c         <= 1'b1;
                pend          <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    // Requesters: raise req while budget remains, drop it when acked.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if (!acked[i]) begin
                        acked[i] = 1'b1;
                        served[i]++;
                    end
                    req[i] = 1'b0;
                end else begin
                    acked[i] = 1'b0;
                    req[i]   = (served[i] < budget[i]);
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the transaction model each cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("rst_soc", soc, 0);
                chk("rst_ack", ack, 0);
                chk("rst_dato", dato, 0);
                mlast    = N - 1;
                exp_pend = 1'b0;
                in_ack   = 1'b0;
            end else begin
                chk("ack_onehot0", $onehot0(ack), 1);
                chk("soc_in_ack", (soc && ack != 4'd0) ? 1 : 0, 0);
                if (soc && !p_soc) begin
                    n_soc++;
                    chk("soc_while_busy", (exp_pend || in_ack) ? 1 : 0, 0);
                    chk("soc_eoc_idle", p_eoc, 1);
                    exp_g = rr_expect(p_req, mlast);
                    chk("soc_has_req", (exp_g >= 0) ? 1 : 0, 1);
                    exp_pend = 1'b1;
                end
                if (ack != 4'd0 && p_ack == 4'd0) begin
                    chk("ack_pending", exp_pend, 1);
                    chk("ack_grant", ack, 1 << exp_g);
                    chk("ack_dato", dato, conv_last_val);
                    for (int i = 0; i < N; i++) if (ack[i]) g_log.push_back(i);
                    d_log.push_back(int'(dato));
                    cur_g    = exp_g;
                    exp_pend = 1'b0;
                    in_ack   = 1'b1;
                    cur_len  = 0;
                end
                if (ack != 4'd0) cur_len++;
                if (ack != 4'd0 && p_ack != 4'd0) begin
                    chk("ack_dato_stable", dato, p_dato);
                    chk("ack_late", p_req[cur_g], 1);
                end
                if (ack == 4'd0 && p_ack != 4'd0) begin
                    chk("ack_early", p_req[cur_g], 0);
                    mlast   = cur_g;
                    in_ack  = 1'b0;
                    ack_len = cur_len;
                    n_done++;
                end
                if (ack == 4'd0 && p_ack == 4'd0) chk("dato_hold", dato, p_dato);
            end
            p_req  = req;
            p_ack  = ack;
            p_soc  = soc;
            p_eoc  = eoc;
            p_dato = dato;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic add_budget(input int i, input int extra);
        budget[i] = served[i] + extra;
    endtask

    task automatic load_val(input int k, input logic [7:0] v);
        vals[(conv_idx + k) % 16] = v;
    endtask

    task automatic wait_done(input string tag, input int target, input int limit);
        int c;
        c = 0;
        while (n_done < target && c < limit) begin
            step(1);
            c++;
        end
        chk({tag, "_timeout"}, (n_done >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_soc(input string tag, input logic lvl, input int limit);
        int c;
        c = 0;
        while (soc !== lvl && c < limit) begin
            step(1);
            c++;
        end
        chk({tag, "_soc_timeout"}, (soc === lvl) ? 1 : 0, 1);
    endtask

    task automatic check_seq(input string tag, input int eg[$], input int ed[$]);
        int base;
        base = g_log.size() - eg.size();
        for (int k = 0; k < eg.size(); k++) begin
            chk($sformatf("%s_grant%0d", tag, k), (base + k >= 0) ? g_log[base + k] : -1, eg[k]);
            chk($sformatf("%s_dato%0d", tag, k), (base + k >= 0) ? d_log[base + k] : -1, ed[k]);
        end
    endtask

    initial begin
        int base_soc;
        int eg[$];
        int ed[$];

        // 1: reset held with all requests up
        #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) add_budget(i, 1);
        step(2);
        for (int i = 0; i < N; i++) budget[i] = served[i];
        step(1);
        reset = 1'b0;
        step(3);
        chk("s1_no_soc", n_soc, 0);

        // 2: single requester 2, result 42, D=3
        conv_delay = 3;
        load_val(0, 8'd42);
        base_soc = n_soc;
        add_budget(2, 1);
        wait_done("s2", n_done + 1, 100);
        step(3);
        chk("s2_soc_count", n_soc - base_soc, 1);
        eg = {2};
        ed = {42};
        check_seq("s2", eg, ed);
        chk("s2_dato_hold", dato, 42);

        // 3: all requesting from a fresh pointer
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        conv_delay = 1;
        for (int k = 0; k < 5; k++) load_val(k, 8'((k + 1) * 10));
        add_budget(0, 2);
        add_budget(1, 1);
        add_budget(2, 1);
        add_budget(3, 1);
        wait_done("s3", n_done + 5, 400);
        eg = {0, 1, 2, 3, 0};
        ed = {10, 20, 30, 40, 50};
        check_seq("s3", eg, ed);

        // 4: serve 1, then 0 and 3 compete
        load_val(0, 8'd7);
        for (int k = 1; k < 5; k++) load_val(k, 8'(70 + k));
        add_budget(1, 1);
        wait_done("s4a", n_done + 1, 100);
        add_budget(0, 2);
        add_budget(3, 2);
        wait_done("s4b", n_done + 4, 400);
        eg = {1, 3, 0, 3, 0};
        ed = {7, 71, 72, 73, 74};
        check_seq("s4", eg, ed);

        // 5: converter busy in IDLE blocks the grant
        load_val(0, 8'd55);
        eoc_force = 1'b1;
        base_soc  = n_soc;
        add_budget(0, 1);
        step(5);
        chk("s5_soc_blocked", n_soc - base_soc, 0);
        eoc_force = 1'b0;
        @(negedge clock);
        chk("s5_soc_not_early", soc, 0);
        @(negedge clock);
        chk("s5_soc_rise", soc, 1);
        wait_done("s5", n_done + 1, 100);
        eg = {0};
        ed = {55};
        check_seq("s5", eg, ed);

        // 7: requester drops req before ack
        load_val(0, 8'd88);
        add_budget(1, 1);
        wait_soc("s7", 1'b1, 50);
        budget[1] = served[1];
        wait_done("s7", n_done + 1, 100);
        chk("s7_ack_len", ack_len, 1);
        eg = {1};
        ed = {88};
        check_seq("s7", eg, ed);

        // 6: reset while waiting for the result
        conv_delay = 6;
        load_val(0, 8'd99);
        for (int k = 1; k < 5; k++) load_val(k, 8'(60 + k));
        add_budget(2, 1);
        wait_soc("s6_hi", 1'b1, 50);
        wait_soc("s6_lo", 1'b0, 50);
        step(1);
        reset = 1'b1;
        #1;
        chk("s6_rst_soc_now", soc, 0);
        chk("s6_rst_ack_now", ack, 0);
        step(2);
        add_budget(0, 1);
        add_budget(1, 1);
        add_budget(3, 1);
        reset = 1'b0;
        wait_done("s6", n_done + 4, 400);
        eg = {0, 1, 2, 3};
        ed = {61, 62, 63, 64};
        check_seq("s6", eg, ed);

        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL watchdog: time limit reached at %0t, want completion", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
